// File: rtl/audio_fir_axil_regs.sv
// AXI4-Lite register file for the audio FIR: CTRL, COEF_ADDR, COEF_DATA, GAIN plus coefficient-RAM write strobe.
// Optional FIR_AXIL_SLVERR_EN: reserved words 4-7 answer SLVERR instead of OKAY.
module audio_fir_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int COEF_AW            = 8,
    parameter int COEF_W             = 18
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          fir_enable,
    output logic                          fir_bypass,
    output logic [15:0]                   fir_gain,
    output logic                          coef_we,
    output logic [COEF_AW-1:0]            coef_addr,
    output logic [COEF_W-1:0]             coef_data
);

    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IW-1:0] IDX_CTRL = IW'(0);
    localparam logic [IW-1:0] IDX_CADDR = IW'(1);
    localparam logic [IW-1:0] IDX_CDATA = IW'(2);
    localparam logic [IW-1:0] IDX_GAIN = IW'(3);
    localparam logic [IW-1:0] IDX_FIRST_RSVD = IW'(4);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef FIR_AXIL_SLVERR_EN
    localparam logic [1:0] RESP_RSVD = 2'b10;
`else
    localparam logic [1:0] RESP_RSVD = 2'b00;
`endif

    logic [31:0] r_ctrl, r_coef_addr, r_coef_data, r_gain;
    logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_coef_we;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;

    logic [IW-1:0] w_wr_idx, w_rd_idx;
    logic          w_wr_start, w_wr_en, w_rd_start, w_rd_en, w_wr_mapped, w_rd_mapped;
    logic [31:0]   w_rd_data;
    logic          w_unused_ok;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign w_wr_idx    = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx    = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_mapped = (w_wr_idx < IDX_FIRST_RSVD);
    assign w_rd_mapped = (w_rd_idx < IDX_FIRST_RSVD);
    // Ready is raised one cycle after both channels are valid; the handshake edge is the following one.
    assign w_wr_start  = s_axi_awvalid && s_axi_wvalid && !r_awready && !r_bvalid;
    assign w_wr_en     = r_awready && s_axi_awvalid && s_axi_wvalid;
    assign w_rd_start  = s_axi_arvalid && !r_arready && !r_rvalid;
    assign w_rd_en     = r_arready && s_axi_arvalid;
    assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Read-data mux over the register map; reserved words read as zero.
    always_comb begin
        w_rd_data = 32'd0;
        case (w_rd_idx)
            IDX_CTRL:  w_rd_data = r_ctrl;
            IDX_CADDR: w_rd_data = r_coef_addr;
            IDX_CDATA: w_rd_data = r_coef_data;
            IDX_GAIN:  w_rd_data = r_gain;
            default:   w_rd_data = 32'd0;
        endcase
    end

    // Write channel: handshake, register updates, B response and coefficient strobe.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_coef_we   <= 1'b0;
            r_ctrl      <= 32'd0;
            r_coef_addr <= 32'd0;
            r_coef_data <= 32'd0;
            r_gain      <= 32'd0;
        end else begin
            r_awready <= w_wr_start;
            r_wready  <= w_wr_start;
            r_coef_we <= 1'b0;
            // Auto-increment lands at the end of the strobe cycle; a write to COEF_ADDR cannot coincide.
            if (r_coef_we && r_ctrl[2]) begin
                r_coef_addr <= r_coef_addr + 32'd1;
            end
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_mapped ? RESP_OKAY : RESP_RSVD;
                case (w_wr_idx)
                    IDX_CTRL:  r_ctrl      <= apply_wstrb(r_ctrl, s_axi_wdata, s_axi_wstrb);
                    IDX_CADDR: r_coef_addr <= apply_wstrb(r_coef_addr, s_axi_wdata, s_axi_wstrb);
                    IDX_CDATA: begin
                        r_coef_data <= apply_wstrb(r_coef_data, s_axi_wdata, s_axi_wstrb);
                        r_coef_we   <= 1'b1;
                    end
                    IDX_GAIN:  r_gain      <= apply_wstrb(r_gain, s_axi_wdata, s_axi_wstrb);
                    default:   ;
                endcase
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: AR handshake captures data/response, held until the master takes it.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_rresp   <= 2'b00;
        end else begin
            r_arready <= w_rd_start;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_mapped ? RESP_OKAY : RESP_RSVD;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign fir_enable    = r_ctrl[0];
    assign fir_bypass    = r_ctrl[1];
    assign fir_gain      = r_gain[15:0];
    assign coef_we       = r_coef_we;
    assign coef_addr     = r_coef_addr[COEF_AW-1:0];
    assign coef_data     = r_coef_data[COEF_W-1:0];

endmodule

// File: tb/tb_audio_fir_axil_regs.sv
// Directed self-checking bench for audio_fir_axil_regs (honours FIR_AXIL_SLVERR_EN when defined).
module tb_audio_fir_axil_regs;

`ifdef FIR_AXIL_SLVERR_EN
    localparam logic [1:0] EXP_RSVD = 2'b10;
`else
    localparam logic [1:0] EXP_RSVD = 2'b00;
`endif

    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic [4:0]  s_axi_awaddr = 5'd0, s_axi_araddr = 5'd0;
    logic [2:0]  s_axi_awprot = 3'd0, s_axi_arprot = 3'd0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic [31:0] s_axi_wdata = 32'd0;
    logic [3:0]  s_axi_wstrb = 4'd0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic        fir_enable, fir_bypass, coef_we;
    logic [15:0] fir_gain;
    logic [7:0]  coef_addr;
    logic [17:0] coef_data;

    int n_checks = 0;
    int n_errors = 0;
    int aw_pulses = 0;
    int coef_pulses = 0;
    logic [7:0]  coef_addr_log [16];
    logic [17:0] coef_data_log [16];

    audio_fir_axil_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .fir_enable(fir_enable), .fir_bypass(fir_bypass),
        .fir_gain(fir_gain), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
    );

    always #5 ACLK = ~ACLK;

    // Passive monitor: counts awready cycles and logs every coefficient strobe.
    always @(negedge ACLK) begin
        if (s_axi_awready) aw_pulses++;
        if (coef_we) begin
            coef_addr_log[coef_pulses % 16] = coef_addr;
            coef_data_log[coef_pulses % 16] = coef_data;
            coef_pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        while (!(s_axi_awready && s_axi_wready) && n < 16) begin @(negedge ACLK); n++; end
        check("wr_ready", {31'd0, s_axi_awready && s_axi_wready}, 32'd1);
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 16) begin @(negedge ACLK); n++; end
        check("wr_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        resp = s_axi_bresp;
        @(posedge ACLK); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 16) begin @(negedge ACLK); n++; end
        check("rd_arready", {31'd0, s_axi_arready}, 32'd1);
        @(posedge ACLK); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < 16) begin @(negedge ACLK); n++; end
        check("rd_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        data = s_axi_rdata; resp = s_axi_rresp;
        @(posedge ACLK); #1;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic        held;
        int          base, n;
        logic [31:0] exp_wr [4];

        // Reset state
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rst_handshakes", {27'd0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 32'd0);
        check("rst_outputs", {13'd0, fir_enable, fir_bypass, coef_we, fir_gain}, 32'd0);
        check("rst_coef", {6'd0, coef_addr, coef_data}, 32'd0);

        // Basic write/readback of all four registers
        exp_wr[0] = 32'd1; exp_wr[1] = 32'd2; exp_wr[2] = 32'd3; exp_wr[3] = 32'd4;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), exp_wr[i], 4'hF, rsp);
            check("wr_bresp", {30'd0, rsp}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), rd, rsp);
            check("rd_basic", rd, exp_wr[i]);
            check("rd_basic_resp", {30'd0, rsp}, 32'd0);
        end
        check("fir_enable", {31'd0, fir_enable}, 32'd1);
        check("fir_bypass", {31'd0, fir_bypass}, 32'd0);
        check("fir_gain", {16'd0, fir_gain}, 32'd4);

        // Coefficient auto-increment: three strobes at 5, 6, 7
        axi_write(5'h00, 32'd4, 4'hF, rsp);
        axi_write(5'h04, 32'd5, 4'hF, rsp);
        base = coef_pulses;
        for (int i = 0; i < 3; i++) axi_write(5'h08, 32'h0003_ABCD, 4'hF, rsp);
        repeat (2) @(negedge ACLK);
        check("coef_pulse_cnt", 32'(coef_pulses - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("coef_we_addr", {24'd0, coef_addr_log[(base + i) % 16]}, 32'd5 + 32'(i));
            check("coef_we_data", {14'd0, coef_data_log[(base + i) % 16]}, 32'h0003_ABCD);
        end
        axi_read(5'h04, rd, rsp);
        check("coef_addr_final", rd, 32'd8);

        // Byte-lane strobe
        axi_write(5'h0C, 32'd0, 4'hF, rsp);
        axi_write(5'h0C, 32'hFFFF_FFFF, 4'b0010, rsp);
        axi_read(5'h0C, rd, rsp);
        check("gain_wstrb", rd, 32'h0000_FF00);

        // AW three cycles ahead of W, bready held off for four cycles
        base = aw_pulses;
        @(negedge ACLK);
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'h0000_0055; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_bready = 1'b0;
        repeat (3) @(negedge ACLK);
        check("aw_alone_wait", 32'(aw_pulses - base), 32'd0);
        s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 16) begin @(negedge ACLK); n++; end
        check("aw_w_ready", {31'd0, s_axi_awready}, 32'd1);
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            held = held & s_axi_bvalid;
        end
        check("bvalid_held", {31'd0, held}, 32'd1);
        check("bresp_held", {30'd0, s_axi_bresp}, 32'd0);
        s_axi_bready = 1'b1;
        @(posedge ACLK); #1;
        s_axi_bready = 1'b0;
        check("bvalid_cleared", {31'd0, s_axi_bvalid}, 32'd0);
        check("single_aw_pulse", 32'(aw_pulses - base), 32'd1);
        axi_read(5'h0C, rd, rsp);
        check("gain_late_w", rd, 32'h0000_0055);

        // Reserved words
        axi_read(5'h14, rd, rsp);
        check("rsvd_rdata", rd, 32'd0);
        check("rsvd_rresp", {30'd0, rsp}, {30'd0, EXP_RSVD});
        axi_write(5'h18, 32'hDEAD_BEEF, 4'hF, rsp);
        check("rsvd_bresp", {30'd0, rsp}, {30'd0, EXP_RSVD});
        axi_read(5'h18, rd, rsp);
        check("rsvd_after_wr", rd, 32'd0);

        // Reset while B response pending
        axi_write(5'h00, 32'h0000_0003, 4'hF, rsp);
        @(negedge ACLK);
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'h0000_1234; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        n = 0;
        while (!s_axi_awready && n < 16) begin @(negedge ACLK); n++; end
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge ACLK);
        check("pre_rst_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        check("pre_rst_gain", {16'd0, fir_gain}, 32'h0000_1234);
        ARESET = 1'b1;
        #1;
        check("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        check("rst_outputs2", {14'd0, fir_enable, fir_bypass, fir_gain}, 32'd0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), rd, rsp);
            check("post_rst_reg", rd, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
